of13_match_table: RTL and testbench
===================================

# of13_match_table

Parametrised OpenFlow 1.3 match stage that follows the Ethernet-type classifier in the `openflow13` datapath. It takes per-packet header fields through a valid/ready handshake and selects the L4 ports by `ip_proto`. It compares the result against `N_ENTRIES` programmable masked match entries and returns the per-entry match `bit_vector` plus the highest-priority hit. The result drives the action/instruction stage downstream.

## Interface
Parameters:
- `N_ENTRIES`, 11: number of match entries and width of `bit_vector`; range 2..64.
- `IDX_W`, `$clog2(N_ENTRIES)`: width of entry index signals.
- `CNT_W`, 32: width of each hit counter; used only when stats are compiled in.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1: header handshake.
- `eth_type` in 16, `ip_proto` in 8, `tcp_src`/`tcp_dst`/`udp_src`/`udp_dst` in 16 each: header fields, sampled on handshake.
- `cfg_we` in 1, `cfg_idx` in IDX_W, `cfg_en` in 1: table write strobe, target entry, entry-valid bit to write.
- `cfg_key` in 56, `cfg_mask` in 56: key and mask to write. Layout is {eth_type[55:40], ip_proto[39:32], l4_src[31:16], l4_dst[15:0]}. A mask bit of 1 means the bit is compared.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `bit_vector` out N_ENTRIES: bit i is set when entry i is enabled and matches.
- `hit` out 1: OR of `bit_vector`.
- `hit_idx` out IDX_W: lowest set index in `bit_vector`; 0 when `hit`=0.
- `l3_class` out 2: 01 = IPv4 (0x0800), 10 = IPv6 (0x86DD), 00 = other.

## Operation
- **S1 (select/register).** On `in_valid & in_ready`:
  - Latch `eth_type` and `ip_proto`.
  - Compute `l3_class`.
  - Select l4_src/l4_dst: TCP ports if `ip_proto`=6 and L3 is IPv4 or IPv6; UDP ports if `ip_proto`=17 and L3 is IPv4 or IPv6; otherwise 0.
  - Form the 56-bit key.
- **S2 (compare).** For every entry i: `match[i] = en[i] & ((key ^ ent_key[i]) & ent_mask[i]) == 0`.
  - Register `bit_vector`, `hit`, `hit_idx` (priority encoder, lowest index wins) and `l3_class`.
- **Backpressure.** Two-stage elastic pipeline with no bubbles:
  - `s2_adv = ~s2_valid | out_ready`.
  - `s1_adv = ~s1_valid | s2_adv`.
  - `in_ready = s1_adv`.
- **Output hold.** While `out_valid & ~out_ready`, all outputs hold stable.
- **Table writes.** A write on cycle t updates the entry at edge t.
  - An S2 compare in cycle t uses the old contents.
  - Compares in cycle t+1 and later use the new contents.
  - Writes never stall the pipeline.
- An all-zero mask with `cfg_en`=1 matches every packet (wildcard entry).
- `cfg_idx` ≥ N_ENTRIES: the write is ignored.

## Timing
- **Latency.** 2 cycles from the input handshake to `out_valid` when unstalled. Throughput is 1 result per cycle.
- **Reset.** Synchronous and clears:
  - all entry enables to 0 (entry keys and masks: don't care);
  - `s1_valid` and `s2_valid`;
  - `out_valid`, `bit_vector`, `hit`, `hit_idx`, `l3_class` to 0.
  - `in_ready`=1 in the first cycle after reset.
- **Reset mid-operation.** In-flight packets are dropped with no output. A `cfg_we` asserted in the reset cycle is ignored.

## Configuration
- `OF13_MATCH_STATS_EN` defined:
  - Adds `stat_idx` (in, IDX_W) and `stat_cnt` (out, CNT_W). `stat_cnt` is the counter of `stat_idx`, registered with 1-cycle latency.
  - The counter of `hit_idx` increments on each `out_valid & out_ready & hit`.
  - Counters saturate at all-ones.
  - A write to an entry clears that entry's counter; reset clears all counters.
- `OF13_MATCH_STATS_EN` not defined: the stat ports and counters are absent. Match behaviour is identical.

## Structure
- **Shared package `of13_pkg`:**
  - constants `ETH_IPV4`=16'h0800, `ETH_IPV6`=16'h86DD, `PROTO_TCP`=8'd6, `PROTO_UDP`=8'd17;
  - `l3_class` encodings;
  - key field offsets and `KEY_W`=56.
- **Sub-module `of13_prio_enc`** (parameterised by N): lowest-set-bit encoder producing `hit` and `hit_idx`. Everything else lives in `of13_match_table`.

## Test plan
- **Post-reset lookup.** Reset; then eth_type=0x0800, ip_proto=6.
  - Expect `bit_vector`=0, `hit`=0, `l3_class`=01, arriving 2 cycles after the handshake.
- **TCP match.** Entry 3 = {0x0800, 6, 0, 80} with mask {FFFF, FF, 0000, FFFF}; packet IPv4/TCP with tcp_dst=80 (udp_dst=53).
  - Expect `bit_vector`=0x008, `hit_idx`=3.
  - Same packet with ip_proto=17 → `bit_vector`=0.
- **Priority.** Entry 0 is a wildcard, plus the entry 3 from the TCP match test; same TCP packet.
  - Expect `bit_vector`=0x009, `hit_idx`=0.
- **Backpressure.** Stream 4 packets with `out_ready` low for 3 cycles.
  - Expect `in_ready` to drop after 2 accepted packets and outputs to hold stable.
  - All 4 results emerge in order with no loss or duplication.
- **Write/compare race.** Enable entry 5 in the same cycle a matching packet sits in S2.
  - That packet reports bit 5 = 0; the next identical packet reports bit 5 = 1.
- **Stats (with `OF13_MATCH_STATS_EN`).** 3 accepted hits on entry 3, one of them held by `out_ready` low for 2 cycles.
  - Expect `stat_cnt`=3.
  - After rewriting entry 3, `stat_cnt`=0.

Source files
------------

// File: rtl/of13_pkg.sv
// Shared OpenFlow 1.3 match-stage definitions: EtherType/IP protocol constants,
// L3 class encodings, the 56-bit match key layout and its field offsets, and the
// EtherType classifier used by the match table.
package of13_pkg;

    localparam logic [15:0] ETH_IPV4  = 16'h0800;
    localparam logic [15:0] ETH_IPV6  = 16'h86DD;
    localparam logic [7:0]  PROTO_TCP = 8'd6;
    localparam logic [7:0]  PROTO_UDP = 8'd17;

    // Key layout {eth_type, ip_proto, l4_src, l4_dst}, MSB first.
    localparam int KEY_W         = 56;
    localparam int KEY_ETH_LSB   = 40;
    localparam int KEY_PROTO_LSB = 32;
    localparam int KEY_L4S_LSB   = 16;
    localparam int KEY_L4D_LSB   = 0;

    typedef enum logic [1:0] {
        L3_OTHER = 2'b00,
        L3_IPV4  = 2'b01,
        L3_IPV6  = 2'b10
    } l3_class_t;

    typedef struct packed {
        logic [15:0] eth_type;
        logic [7:0]  ip_proto;
        logic [15:0] l4_src;
        logic [15:0] l4_dst;
    } key_t;

    function automatic l3_class_t classify_l3(input logic [15:0] et);
        l3_class_t c;
        c = L3_OTHER;
        if (et == ETH_IPV4) begin
            c = L3_IPV4;
        end else if (et == ETH_IPV6) begin
            c = L3_IPV6;
        end
        return c;
    endfunction

endpackage

// File: rtl/of13_prio_enc.sv
// Lowest-set-bit priority encoder over the per-entry match vector.
// Latency: combinational. Backpressure: none (pure function of i_vec).
// Ports: i_vec (N) in; o_hit = OR of i_vec; o_idx = lowest set index, 0 when none set.
module of13_prio_enc #(
    parameter int N     = 11,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_hit = |i_vec;
        o_idx = '0;
        // Scan downward so the lowest set bit is the last assignment and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/of13_match_table.sv
// OpenFlow 1.3 masked match stage: L4 port select, N_ENTRIES key/mask compare, priority hit.
// Latency: 2 cycles from input handshake to out_valid; 1 result per cycle.
// Backpressure: two-stage elastic pipeline, no bubbles; outputs hold while out_valid & ~out_ready.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready + header fields; cfg_we/cfg_idx/cfg_en/
// cfg_key/cfg_mask table write (out-of-range cfg_idx ignored, never stalls); out_valid/out_ready
// + bit_vector/hit/hit_idx/l3_class result.
// Optional macro OF13_MATCH_STATS_EN adds stat_idx/stat_cnt and per-entry saturating hit counters.
module of13_match_table
    import of13_pkg::*;
#(
    parameter int N_ENTRIES = 11,
    parameter int IDX_W     = $clog2(N_ENTRIES)
`ifdef OF13_MATCH_STATS_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          eth_type,
    input  logic [7:0]           ip_proto,
    input  logic [15:0]          tcp_src,
    input  logic [15:0]          tcp_dst,
    input  logic [15:0]          udp_src,
    input  logic [15:0]          udp_dst,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic                 cfg_en,
    input  logic [KEY_W-1:0]     cfg_key,
    input  logic [KEY_W-1:0]     cfg_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_ENTRIES-1:0] bit_vector,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx,
    output logic [1:0]           l3_class
`ifdef OF13_MATCH_STATS_EN
    ,
    input  logic [IDX_W-1:0]     stat_idx,
    output logic [CNT_W-1:0]     stat_cnt
`endif
);

    // ---------------- handshake ----------------
    logic w_s1_adv;
    logic w_s2_adv;
    logic r_s1_valid;
    logic r_s2_valid;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    // ---------------- table ----------------
    logic [N_ENTRIES-1:0] r_en;
    logic [KEY_W-1:0]     r_ent_key  [N_ENTRIES];
    logic [KEY_W-1:0]     r_ent_mask [N_ENTRIES];
    logic                 w_cfg_ok;

    // Extra index bit so N_ENTRIES is representable even when it is a power of two.
    assign w_cfg_ok = cfg_we & ({1'b0, cfg_idx} < (IDX_W + 1)'(N_ENTRIES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= '0;
        end else if (w_cfg_ok) begin
            r_en[cfg_idx] <= cfg_en;
        end
    end

    // Key/mask need no reset: an entry is inert until its enable is written.
    always_ff @(posedge clk) begin
        if (!rst && w_cfg_ok) begin
            r_ent_key[cfg_idx]  <= cfg_key;
            r_ent_mask[cfg_idx] <= cfg_mask;
        end
    end

    // ---------------- S1: classify, select L4, build key ----------------
    l3_class_t        w_l3_in;
    logic [15:0]      w_l4_src;
    logic [15:0]      w_l4_dst;
    key_t             w_key_in;
    logic [KEY_W-1:0] r_s1_key;
    l3_class_t        r_s1_l3;

    assign w_l3_in = classify_l3(eth_type);

    always_comb begin
        w_l4_src = '0;
        w_l4_dst = '0;
        if (w_l3_in != L3_OTHER) begin
            if (ip_proto == PROTO_TCP) begin
                w_l4_src = tcp_src;
                w_l4_dst = tcp_dst;
            end else if (ip_proto == PROTO_UDP) begin
                w_l4_src = udp_src;
                w_l4_dst = udp_dst;
            end
        end
    end

    assign w_key_in = '{eth_type: eth_type, ip_proto: ip_proto,
                        l4_src: w_l4_src, l4_dst: w_l4_dst};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_key   <= '0;
            r_s1_l3    <= L3_OTHER;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_key <= w_key_in;
                r_s1_l3  <= w_l3_in;
            end
        end
    end

    // ---------------- S2: compare against table ----------------
    // Compares read the table registers directly, so a write landing on the
    // same edge that captures this result is not seen until the next compare.
    logic [N_ENTRIES-1:0] w_match;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_hit_idx;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_match[i] = r_en[i] & (((r_s1_key ^ r_ent_key[i]) & r_ent_mask[i]) == '0);
        end
    end

    of13_prio_enc #(
        .N     (N_ENTRIES),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_vec (w_match),
        .o_hit (w_hit),
        .o_idx (w_hit_idx)
    );

    logic [N_ENTRIES-1:0] r_bv;
    logic                 r_hit;
    logic [IDX_W-1:0]     r_hit_idx;
    l3_class_t            r_l3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_bv       <= '0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_l3       <= L3_OTHER;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_bv      <= w_match;
                r_hit     <= w_hit;
                r_hit_idx <= w_hit_idx;
                r_l3      <= r_s1_l3;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign bit_vector = r_bv;
    assign hit        = r_hit;
    assign hit_idx    = r_hit_idx;
    assign l3_class   = r_l3;

`ifdef OF13_MATCH_STATS_EN
    // ---------------- per-entry hit counters ----------------
    logic [CNT_W-1:0] r_cnt [N_ENTRIES];
    logic [CNT_W-1:0] r_stat_cnt;
    logic             w_out_hit;

    assign w_out_hit = r_s2_valid & out_ready & r_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                // A rewrite restarts the entry's statistics, even over a same-cycle hit.
                if (w_cfg_ok && cfg_idx == IDX_W'(i)) begin
                    r_cnt[i] <= '0;
                end else if (w_out_hit && r_hit_idx == IDX_W'(i) && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cnt <= '0;
        end else if ({1'b0, stat_idx} < (IDX_W + 1)'(N_ENTRIES)) begin
            r_stat_cnt <= r_cnt[stat_idx];
        end else begin
            r_stat_cnt <= '0;
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_of13_match_table.sv
module tb_of13_match_table;

    localparam int N  = 11;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   eth_type;
    logic [7:0]    ip_proto;
    logic [15:0]   tcp_src, tcp_dst, udp_src, udp_dst;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic          cfg_en;
    logic [55:0]   cfg_key, cfg_mask;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  bit_vector;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [1:0]    l3_class;
`ifdef OF13_MATCH_STATS_EN
    logic [IW-1:0] stat_idx;
    logic [31:0]   stat_cnt;
`endif

    always #5 clk = ~clk;

    of13_match_table #(.N_ENTRIES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .eth_type   (eth_type),
        .ip_proto   (ip_proto),
        .tcp_src    (tcp_src),
        .tcp_dst    (tcp_dst),
        .udp_src    (udp_src),
        .udp_dst    (udp_dst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_key    (cfg_key),
        .cfg_mask   (cfg_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bit_vector (bit_vector),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .l3_class   (l3_class)
`ifdef OF13_MATCH_STATS_EN
        ,
        .stat_idx   (stat_idx),
        .stat_cnt   (stat_cnt)
`endif
    );

    typedef struct {
        logic [N-1:0]  bv;
        logic          hit;
        logic [IW-1:0] idx;
        logic [1:0]    l3;
        int            lat;
        int            hs_cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic chk_lat;

    localparam logic [55:0] K_TCP80  = {16'h0800, 8'd6, 16'h0000, 16'd80};
    localparam logic [55:0] K_UDP53  = {16'h0800, 8'd17, 16'h0000, 16'd53};
    localparam logic [55:0] M_NOSRC  = {16'hFFFF, 8'hFF, 16'h0000, 16'hFFFF};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops one expectation per accepted output and checks that
    // a stalled output does not change before it is taken.
    logic        hold_pend = 1'b0;
    logic [18:0] hold_snap;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_stable", {out_valid, bit_vector, hit, hit_idx, l3_class}, hold_snap);
            end
            hold_pend = out_valid & ~out_ready;
            hold_snap = {out_valid, bit_vector, hit, hit_idx, l3_class};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got bv=0x%0h with no pending packet", bit_vector);
                end else begin
                    e = q.pop_front();
                    check("bit_vector", 64'(bit_vector), 64'(e.bv));
                    check("hit", 64'(hit), 64'(e.hit));
                    check("hit_idx", 64'(hit_idx), 64'(e.idx));
                    check("l3_class", 64'(l3_class), 64'(e.l3));
                    if (e.lat > 0) check("latency", 64'(cyc - e.hs_cyc), 64'(e.lat));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [15:0] et, input logic [7:0] pr,
                        input logic [15:0] ts, input logic [15:0] td,
                        input logic [15:0] us, input logic [15:0] ud,
                        input logic [N-1:0] bv, input logic h,
                        input logic [IW-1:0] idx, input logic [1:0] l3);
        exp_t e;
        int   n;
        eth_type = et; ip_proto = pr;
        tcp_src = ts; tcp_dst = td; udp_src = us; udp_dst = ud;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            e.bv = bv; e.hit = h; e.idx = idx; e.l3 = l3;
            e.lat = chk_lat ? 2 : 0;
            e.hs_cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic en,
                             input logic [55:0] key, input logic [55:0] mask);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_key = key; cfg_mask = mask;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; chk_lat = 1'b1;
        eth_type = '0; ip_proto = '0; tcp_src = '0; tcp_dst = '0; udp_src = '0; udp_dst = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_key = '0; cfg_mask = '0;
`ifdef OF13_MATCH_STATS_EN
        stat_idx = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bit_vector", 64'(bit_vector), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_hit_idx", 64'(hit_idx), 64'd0);
        check("rst_l3_class", 64'(l3_class), 64'd0);
        @(posedge clk); #1;

        // Post-reset lookup: empty table, IPv4 class, 2-cycle latency
        send(16'h0800, 8'd6, 16'd1234, 16'd80, 16'd5, 16'd53, 11'h000, 1'b0, 4'd0, 2'b01);
        drain();

        // TCP match on entry 3, L4 selection by protocol and L3 class
        cfg_write(4'd3, 1'b1, K_TCP80, M_NOSRC);
        send(16'h0800, 8'd6,  16'd1234, 16'd80, 16'd5, 16'd53, 11'h008, 1'b1, 4'd3, 2'b01);
        send(16'h0800, 8'd17, 16'd1234, 16'd80, 16'd5, 16'd53, 11'h000, 1'b0, 4'd0, 2'b01);
        send(16'h86DD, 8'd6,  16'd1234, 16'd80, 16'd5, 16'd53, 11'h000, 1'b0, 4'd0, 2'b10);
        send(16'h0806, 8'd6,  16'd1234, 16'd80, 16'd5, 16'd53, 11'h000, 1'b0, 4'd0, 2'b00);

        // Priority: wildcard entry 0 beats entry 3
        cfg_write(4'd0, 1'b1, 56'd0, 56'd0);
        send(16'h0800, 8'd6,  16'd1234, 16'd80, 16'd5, 16'd53, 11'h009, 1'b1, 4'd0, 2'b01);
        send(16'h0806, 8'd0,  16'd0,    16'd0,  16'd0, 16'd0,  11'h001, 1'b1, 4'd0, 2'b00);

        // Last entry works; index N is ignored
        cfg_write(4'd0, 1'b0, 56'd0, 56'd0);
        cfg_write(4'd10, 1'b1, 56'd0, 56'd0);
        cfg_write(4'd11, 1'b0, 56'd0, 56'd0);
        send(16'h0806, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 11'h400, 1'b1, 4'd10, 2'b00);
        drain();

        // Backpressure: out_ready low for 3 cycles while streaming 4 packets
        chk_lat = 1'b0;
        out_ready = 1'b0;
        send(16'h0800, 8'd6, 16'd1, 16'd80, 16'd0, 16'd0, 11'h408, 1'b1, 4'd3, 2'b01);
        send(16'h0806, 8'd0, 16'd0, 16'd0,  16'd0, 16'd0, 11'h400, 1'b1, 4'd10, 2'b00);
        eth_type = 16'h86DD; ip_proto = 8'd17; udp_src = 16'd7; udp_dst = 16'd53;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_bv", 64'(bit_vector), 64'h408);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h86DD, 8'd17, 16'd0, 16'd0, 16'd7, 16'd53, 11'h400, 1'b1, 4'd10, 2'b10);
        send(16'h0800, 8'd6,  16'd2, 16'd80, 16'd0, 16'd0, 11'h408, 1'b1, 4'd3, 2'b01);
        drain();
        chk_lat = 1'b1;

        // Write/compare race: entry 5 written while the packet is being compared
        send(16'h0800, 8'd17, 16'd0, 16'd0, 16'd9, 16'd53, 11'h400, 1'b1, 4'd10, 2'b01);
        cfg_write(4'd5, 1'b1, K_UDP53, M_NOSRC);
        send(16'h0800, 8'd17, 16'd0, 16'd0, 16'd9, 16'd53, 11'h420, 1'b1, 4'd5, 2'b01);
        drain();

`ifdef OF13_MATCH_STATS_EN
        // Stats: 3 hits on entry 3, one stalled; rewrite clears
        cfg_write(4'd3, 1'b1, K_TCP80, M_NOSRC);
        send(16'h0800, 8'd6, 16'd1, 16'd80, 16'd0, 16'd0, 11'h408, 1'b1, 4'd3, 2'b01);
        send(16'h0800, 8'd6, 16'd2, 16'd80, 16'd0, 16'd0, 11'h408, 1'b1, 4'd3, 2'b01);
        drain();
        chk_lat = 1'b0;
        out_ready = 1'b0;
        send(16'h0800, 8'd6, 16'd3, 16'd80, 16'd0, 16'd0, 11'h408, 1'b1, 4'd3, 2'b01);
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        drain();
        chk_lat = 1'b1;
        stat_idx = 4'd3;
        @(posedge clk); #1;
        check("stat_cnt_3hits", 64'(stat_cnt), 64'd3);
        cfg_write(4'd3, 1'b1, K_TCP80, M_NOSRC);
        @(posedge clk); #1;
        check("stat_cnt_cleared", 64'(stat_cnt), 64'd0);
`endif

        // Reset mid-operation: in-flight packet dropped, cfg write in reset ignored
        eth_type = 16'h0806; ip_proto = 8'd0;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_en = 1'b1; cfg_key = '0; cfg_mask = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_output", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(16'h0806, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 11'h000, 1'b0, 4'd0, 2'b00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
